// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: a small circular buffer with a valid/ready head and flush.
// Define IFQ_BYPASS_EN to let an empty queue forward the fetch entry to decode in the same cycle.
module if_id_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 2,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    // fetch side
    input  logic                   if_valid,
    input  logic [XLEN-1:0]        if_pc,
    input  logic [XLEN-1:0]        if_inst,
    input  logic                   if_int_flag,
    input  logic                   if_exp_flag,
    output logic                   ifq_ready,
    // control
    input  logic                   flush,
    // decode side
    input  logic                   id_ready,
    output logic                   id_valid,
    output logic [XLEN-1:0]        id_pc,
    output logic [XLEN-1:0]        id_inst,
    output logic                   id_int_flag,
    output logic                   id_exp_flag,
    output logic [$clog2(DEPTH):0] ifq_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [XLEN-1:0] inst_mem_q [DEPTH];
    logic            int_mem_q  [DEPTH];
    logic            exp_mem_q  [DEPTH];

    logic            full;
    logic            empty;
    logic            bypass;
    logic            push;
    logic            pop;
    logic            wr_en;
    logic            rd_en;

    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_inst;
    logic            head_int;
    logic            head_exp;

    // Handshake decode. ifq_ready depends only on registered occupancy.
    always_comb begin
        full      = (count_q == CntW'(DEPTH));
        empty     = (count_q == '0);
        ifq_ready = ~full;
        bypass    = 1'b0;
`ifdef IFQ_BYPASS_EN
        bypass    = empty & if_valid & ~flush;
`endif
        id_valid  = ~empty | bypass;
        push      = if_valid & ifq_ready & ~flush;
        pop       = id_valid & id_ready & ~flush;
        // A bypassed entry taken by decode is never written to storage.
        wr_en     = push & ~(bypass & id_ready);
        rd_en     = pop & ~empty;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem_q[wr_ptr_q]   <= if_pc;
            inst_mem_q[wr_ptr_q] <= if_inst;
            int_mem_q[wr_ptr_q]  <= if_int_flag;
            exp_mem_q[wr_ptr_q]  <= if_exp_flag;
        end
    end

    always_comb begin
        head_pc   = pc_mem_q[rd_ptr_q];
        head_inst = inst_mem_q[rd_ptr_q];
        head_int  = int_mem_q[rd_ptr_q];
        head_exp  = exp_mem_q[rd_ptr_q];
`ifdef IFQ_BYPASS_EN
        if (bypass) begin
            head_pc   = if_pc;
            head_inst = if_inst;
            head_int  = if_int_flag;
            head_exp  = if_exp_flag;
        end
`endif
    end

    // Faulting fetches reach decode as a NOP so only the exception flag acts on them.
    always_comb begin
        id_pc       = '0;
        id_inst     = NOP_INST;
        id_int_flag = 1'b0;
        id_exp_flag = 1'b0;
        if (id_valid) begin
            id_pc       = head_pc;
            id_int_flag = head_int;
            id_exp_flag = head_exp;
            id_inst     = head_exp ? NOP_INST : head_inst;
        end
    end

    assign ifq_count = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus random traffic checked against a queue model.
// Follows IFQ_BYPASS_EN the same way the design does.
module tb_if_id_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_inst;
    logic            if_int_flag;
    logic            if_exp_flag;
    logic            ifq_ready;
    logic            flush;
    logic            id_ready;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_inst;
    logic            id_int_flag;
    logic            id_exp_flag;
    logic [$clog2(DEPTH):0] ifq_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        intf;
        logic        expf;
    } ent_t;

    ent_t mq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    if_id_queue #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .NOP_INST(NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .if_int_flag(if_int_flag),
        .if_exp_flag(if_exp_flag),
        .ifq_ready  (ifq_ready),
        .flush      (flush),
        .id_ready   (id_ready),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .id_int_flag(id_int_flag),
        .id_exp_flag(id_exp_flag),
        .ifq_count  (ifq_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_bypass();
`ifdef IFQ_BYPASS_EN
        return (mq.size() == 0) && if_valid && !flush;
`else
        return 1'b0;
`endif
    endfunction

    // Compare every output against the model for the currently driven inputs.
    task automatic check_outputs();
        bit   byp;
        bit   vld;
        ent_t hd;
        byp = model_bypass();
        vld = (mq.size() != 0) || byp;
        hd  = '0;
        if (mq.size() != 0) hd = mq[0];
        else if (byp) hd = '{pc: if_pc, inst: if_inst, intf: if_int_flag, expf: if_exp_flag};
        check_eq("id_valid", 32'(id_valid), 32'(vld));
        check_eq("id_pc", id_pc, vld ? hd.pc : 32'h0);
        check_eq("id_inst", id_inst, (!vld || hd.expf) ? NOP : hd.inst);
        check_eq("id_int_flag", 32'(id_int_flag), 32'(vld & hd.intf));
        check_eq("id_exp_flag", 32'(id_exp_flag), 32'(vld & hd.expf));
        check_eq("ifq_ready", 32'(ifq_ready), 32'(mq.size() != DEPTH));
        check_eq("ifq_count", 32'(ifq_count), 32'(mq.size()));
    endtask

    // Queue semantics at the clock edge for the currently driven inputs.
    task automatic model_update();
        int   sz;
        bit   byp;
        bit   push;
        bit   pop;
        ent_t e;
        sz   = mq.size();
        byp  = model_bypass();
        push = if_valid && (sz != DEPTH);
        pop  = ((sz != 0) || byp) && id_ready;
        e    = '{pc: if_pc, inst: if_inst, intf: if_int_flag, expf: if_exp_flag};
        if (flush) begin
            mq.delete();
        end else if (!(byp && id_ready)) begin
            if (pop && sz != 0) void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
    endtask

    // Called one time unit after a rising edge; returns at the same phase one cycle later.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic i_f, input logic e_f, input logic fl, input logic rdy);
        if_valid    = v;
        if_pc       = pc;
        if_inst     = inst;
        if_int_flag = i_f;
        if_exp_flag = e_f;
        flush       = fl;
        id_ready    = rdy;
        #3;
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        rst_n       = 1'b0;
        if_valid    = 1'b0;
        if_pc       = '0;
        if_inst     = '0;
        if_int_flag = 1'b0;
        if_exp_flag = 1'b0;
        flush       = 1'b0;
        id_ready    = 1'b0;
        #3;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming with decode always ready.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b1);
            check_eq("stream_cnt_le1", 32'(ifq_count <= 1), 32'h1);
        end
        idle(1'b1);
        idle(1'b1);

        // Fill, stall fetch, drain across the pointer wrap.
        step(1'b1, 32'h10, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h14, 32'hA1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("full_ready", 32'(ifq_ready), 32'h0);
        step(1'b1, 32'h18, 32'hA2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h18, 32'hA2, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h18, 32'hA2, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush with a colliding push and pop.
        step(1'b1, 32'h20, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h24, 32'hB1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h100, 32'hB2, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("flush_count", 32'(ifq_count), 32'h0);
        check_eq("flush_ready", 32'(ifq_ready), 32'h1);
        step(1'b1, 32'h200, 32'hB3, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("post_flush_pc", id_pc, 32'h200);
        idle(1'b1);

        // Fetch exception turns the instruction into a NOP.
        step(1'b1, 32'h6, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("exp_pc", id_pc, 32'h6);
        check_eq("exp_flag", 32'(id_exp_flag), 32'h1);
        check_eq("exp_inst", id_inst, NOP);
        idle(1'b1);

        // Empty queue offered a push while decode is ready (bypass case when enabled).
        step(1'b1, 32'h40, 32'hC0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);

        // Asynchronous reset with two entries held.
        step(1'b1, 32'h50, 32'hD0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h54, 32'hD1, 1'b0, 1'b0, 1'b0, 1'b0);
        if_valid = 1'b0;
        id_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        check_eq("rst_valid", 32'(id_valid), 32'h0);
        check_eq("rst_count", 32'(ifq_count), 32'h0);
        check_eq("rst_ready", 32'(ifq_ready), 32'h1);
        check_eq("rst_inst", id_inst, NOP);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC, $urandom,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage and decode. Each cycle it captures the fetch stage's PC, instruction word and trap flags, and holds them in a small circular buffer. It presents the oldest entry to decode with a valid/ready handshake, and drops everything on a branch/jump flush. Fetch stalls from this block's `ifq_ready`; decode can stall without losing fetched instructions.

## Interface
Parameters:
- `DEPTH`, default 2: number of entries; power of two, ≥2.
- `NOP_INST`, default `32'h0000_0013`: word driven on `id_inst` when the queue is empty or the head entry carries an exception.

Ports (`XLEN` from `defines.v`):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `if_valid` in 1: fetch offers an entry this cycle.
- `if_pc` in XLEN: PC of the offered entry.
- `if_inst` in XLEN: instruction word of the offered entry.
- `if_int_flag` in 1: interrupt pending, attached to the entry.
- `if_exp_flag` in 1: fetch exception (misaligned PC), attached to the entry.
- `ifq_ready` out 1: queue accepts a push this cycle; fetch drives `pipe_stall = ~ifq_ready`.
- `flush` in 1: branch/jump taken (`bj_flag`); discard all entries.
- `id_ready` in 1: decode consumes the head this cycle.
- `id_valid` out 1: head entry valid.
- `id_pc` out XLEN: PC of the head entry.
- `id_inst` out XLEN: instruction word of the head entry.
- `id_int_flag` out 1: interrupt flag of the head entry.
- `id_exp_flag` out 1: exception flag of the head entry.
- `ifq_count` out $clog2(DEPTH)+1: current occupancy.

## Operation
State:
- `rd_ptr` and `wr_ptr`, each $clog2(DEPTH) bits, wrap modulo DEPTH.
- `count`, 0..DEPTH.
- Per-entry storage: pc, inst, int flag, exp flag.

Handshake signals:
- `ifq_ready = (count != DEPTH)`. It never depends on `id_ready`, so the path stays registered.
- push = `if_valid & ifq_ready & ~flush`: write the entry at `wr_ptr`, then `wr_ptr++`.
- pop = `id_valid & id_ready & ~flush`: `rd_ptr++`.
- Push and pop in the same cycle leave `count` unchanged. Otherwise `count` moves by ±1.

Flush:
- Has priority over push and pop.
- Next edge sets `rd_ptr = wr_ptr = count = 0`.
- The same-cycle push is dropped and no pop is reported.

Output data:
- `id_valid = (count != 0)`.
- Output fields come from entry `rd_ptr`.
- If `id_exp_flag` is set, `id_inst` is forced to NOP_INST; the PC and flags still pass through.
- When empty: `id_pc = 0`, `id_inst = NOP_INST`, and both flags are 0.

Other rules:
- Pushes with `if_valid=0` are ignored; payload inputs are don't-care.
- `id_ready` while empty is ignored.

Reset:
- Pointers and `count` go to 0.
- Entry storage is not cleared.
- Outputs: `id_valid=0`, `id_pc=0`, `id_inst=NOP_INST`, `id_int_flag=0`, `id_exp_flag=0`, `ifq_ready=1`, `ifq_count=0`.
- Reset asserted mid-operation discards all entries immediately and asynchronously.

## Timing
- Push to visible at head: 1 cycle (entry pushed at edge N is presented on `id_valid` after edge N, if the queue was empty).
- Sustained throughput: 1 entry/cycle when `id_ready=1` continuously.
- Full (`count=DEPTH`):
  - `ifq_ready=0` even if decode pops in the same cycle.
  - `ifq_ready` returns to 1 the cycle after the pop.
- Flush at edge N: `id_valid=0` and `ifq_ready=1` after edge N. The first new entry can be pushed in cycle N+1.
- Pointer wrap: `DEPTH-1 → 0`, with no bubble.

## Configuration
`IFQ_BYPASS_EN` compiles the empty-queue bypass in or out.

With `IFQ_BYPASS_EN` defined, when `count==0 & if_valid & ~flush`:
- `id_valid=1` in the same cycle, with `id_*` driven combinationally from `if_*` (NOP substitution still applies).
- If `id_ready=1`, the entry is consumed and not written; `count` stays 0.
- Otherwise it is written normally.

Without `IFQ_BYPASS_EN`:
- Latency is always 1 cycle as above.
- `id_*` are pure functions of queue state; there is no combinational `if_*`→`id_*` path.

## Test plan
- Reset: assert `rst_n=0` mid-stream with 2 entries held → `id_valid=0`, `ifq_count=0`, `ifq_ready=1`, `id_inst=32'h13` immediately, before any clock edge.
- Streaming: push PCs 0x0, 0x4, 0x8, 0xC on consecutive cycles with `id_ready=1` → `id_pc` shows 0x0..0xC in order, one cycle after each push (bypass off), with no bubbles; `ifq_count` stays ≤1.
- Fill/drain with DEPTH=2:
  - Hold `id_ready=0` and push 3 entries → `ifq_ready=0` after 2 pushes; the third is held by fetch.
  - Release `id_ready` → order preserved across the pointer wrap; the third entry is accepted the cycle after the first pop.
- Flush: with 2 entries held, assert `flush` together with `if_valid` (PC 0x100) and `id_ready` → after the edge, `count=0`, PC 0x100 is never presented, and the next push (PC 0x200) appears 1 cycle later.
- Exception: push PC 0x6 with `if_exp_flag=1` and `if_inst=32'hDEADBEEF` → head shows `id_pc=0x6`, `id_exp_flag=1`, `id_inst=32'h13`.
- Bypass (`IFQ_BYPASS_EN`): empty queue, push PC 0x40 with `id_ready=1` → `id_valid=1` and `id_pc=0x40` in the same cycle; `ifq_count` stays 0.
